uvma_clknrst_rst_seq: RTL and testbench

Synthesizable reset/clock-gating sequencer at the driving end of the clock-and-reset interface. It accepts timed commands over a valid/ready port and produces the DUT-side active-low reset and a clock-gate enable with cycle-exact pulse widths and post-release settle time. It sits between the clknrst agent's command path and the DUT clock gate and reset pins. It is the source of the waveforms that the interface checks observe.

---
 rtl/uvma_clknrst_rst_seq_pkg.sv | 23 ++
 rtl/uvma_clknrst_cycle_cnt.sv | 29 ++
 rtl/uvma_clknrst_rst_seq.sv | 179 +++++++++++++++++
 tb/tb_uvma_clknrst_rst_seq.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uvma_clknrst_rst_seq_pkg.sv
// Shared encodings for the clock/reset sequencer: command opcodes, FSM states
// and the saturation limit of the reset-release counter.
package uvma_clknrst_rst_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_ASSERT    = 3'd1,
        OP_DEASSERT  = 3'd2,
        OP_PULSE     = 3'd3,
        OP_CLK_STOP  = 3'd4,
        OP_CLK_START = 3'd5
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PULSE_LOW = 2'd1,
        ST_SETTLE    = 2'd2,
        ST_CLK_OFF   = 2'd3
    } seq_state_e;

    localparam int RST_CNT_MAX = 255;

endpackage

// File: rtl/uvma_clknrst_cycle_cnt.sv
// Loadable down-counter that parks at zero; load has priority over counting.
module uvma_clknrst_cycle_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_srst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count   = r_count;
    assign o_expired = (r_count == '0);

endmodule

// File: rtl/uvma_clknrst_rst_seq.sv
// Reset / clock-gate sequencer: turns timed commands into a DUT active-low reset
// and clock enable with cycle-exact pulse widths and a post-release settle window.
module uvma_clknrst_rst_seq
    import uvma_clknrst_rst_seq_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cycles,
    output logic             dut_reset_n,
    output logic             clk_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       rst_count
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam bit               SETTLE_ONE  = (SETTLE_CYCLES == 1);

    seq_state_e       r_state, w_state_next;
    logic             r_dut_reset_n, w_dut_reset_n_next;
    logic             r_clk_en, w_clk_en_next;
    logic             r_busy, w_busy_next;
    logic             r_done, w_done_next;
    logic             r_err, w_err_next;
    logic [7:0]       r_rst_count, w_rst_count_next;
    logic             w_accept, w_release;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_load_val, w_cnt_count, w_pulse_load;
    logic             w_cnt_expired, w_cnt_one;

    uvma_clknrst_cycle_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk        (clk),
        .i_srst     (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_en       (1'b1),
        .o_count    (w_cnt_count),
        .o_expired  (w_cnt_expired)
    );

    assign cmd_ready    = (r_state == ST_IDLE) && !reset;
    assign w_accept     = cmd_valid && cmd_ready;
    assign w_cnt_one    = (w_cnt_count == CNT_W'(1));
    assign w_pulse_load = (cmd_cycles == '0) ? '0 : cmd_cycles - CNT_W'(1);

    // done is registered, so it is raised on the edge entering the final busy
    // cycle: counter==1 now means counter==0 (expiry) next cycle.
    always_comb begin
        w_state_next       = r_state;
        w_dut_reset_n_next = r_dut_reset_n;
        w_clk_en_next      = r_clk_en;
        w_busy_next        = r_busy;
        w_done_next        = 1'b0;
        w_err_next         = 1'b0;
        w_release          = 1'b0;
        w_cnt_load         = 1'b0;
        w_cnt_load_val     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_NOP: w_done_next = 1'b1;
                        OP_ASSERT: begin
                            w_dut_reset_n_next = 1'b0;
                            w_done_next        = 1'b1;
                        end
                        OP_DEASSERT: begin
                            w_clk_en_next = 1'b1;
                            if (!r_dut_reset_n) begin
                                w_state_next       = ST_SETTLE;
                                w_dut_reset_n_next = 1'b1;
                                w_busy_next        = 1'b1;
                                w_cnt_load         = 1'b1;
                                w_cnt_load_val     = SETTLE_LOAD;
                                w_done_next        = SETTLE_ONE;
                                w_release          = SETTLE_ONE;
                            end else begin
                                w_done_next = 1'b1;
                            end
                        end
                        OP_PULSE: begin
                            w_state_next       = ST_PULSE_LOW;
                            w_dut_reset_n_next = 1'b0;
                            w_clk_en_next      = 1'b1;
                            w_busy_next        = 1'b1;
                            w_cnt_load         = 1'b1;
                            w_cnt_load_val     = w_pulse_load;
                        end
                        OP_CLK_STOP: begin
                            w_clk_en_next = 1'b0;
                            if (cmd_cycles == '0) begin
                                w_done_next = 1'b1;
                            end else begin
                                w_state_next   = ST_CLK_OFF;
                                w_busy_next    = 1'b1;
                                w_cnt_load     = 1'b1;
                                w_cnt_load_val = cmd_cycles - CNT_W'(1);
                                w_done_next    = (cmd_cycles == CNT_W'(1));
                            end
                        end
                        OP_CLK_START: begin
                            w_clk_en_next = 1'b1;
                            w_done_next   = 1'b1;
                        end
                        default: w_err_next = 1'b1;
                    endcase
                end
            end
            ST_PULSE_LOW: begin
                if (w_cnt_expired) begin
                    w_state_next       = ST_SETTLE;
                    w_dut_reset_n_next = 1'b1;
                    w_cnt_load         = 1'b1;
                    w_cnt_load_val     = SETTLE_LOAD;
                    w_done_next        = SETTLE_ONE;
                    w_release          = SETTLE_ONE;
                end
            end
            ST_SETTLE: begin
                if (w_cnt_expired) begin
                    w_state_next = ST_IDLE;
                    w_busy_next  = 1'b0;
                end else if (w_cnt_one) begin
                    w_done_next = 1'b1;
                    w_release   = 1'b1;
                end
            end
            ST_CLK_OFF: begin
                if (w_cnt_expired) begin
                    w_state_next  = ST_IDLE;
                    w_busy_next   = 1'b0;
                    w_clk_en_next = 1'b1;
                end else if (w_cnt_one) begin
                    w_done_next = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        w_rst_count_next = r_rst_count;
        if (w_release && (r_rst_count != 8'(RST_CNT_MAX))) begin
            w_rst_count_next = r_rst_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_dut_reset_n <= 1'b0;
            r_clk_en      <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_rst_count   <= 8'd0;
        end else begin
            r_state       <= w_state_next;
            r_dut_reset_n <= w_dut_reset_n_next;
            r_clk_en      <= w_clk_en_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
            r_err         <= w_err_next;
            r_rst_count   <= w_rst_count_next;
        end
    end

    assign dut_reset_n = r_dut_reset_n;
    assign clk_en      = r_clk_en;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign rst_count   = r_rst_count;

endmodule

// File: tb/tb_uvma_clknrst_rst_seq.sv
// Self-checking bench: each command's expected waveform is derived from its
// timeline (offset k after acceptance) and compared every cycle.
module tb_uvma_clknrst_rst_seq;

    localparam int CNT_W = 16;
    localparam int S     = 4;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cycles;
    logic             dut_reset_n;
    logic             clk_en;
    logic             busy;
    logic             done;
    logic             err;
    logic [7:0]       rst_count;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: what the DUT pins should rest at while idle
    logic m_rst_n;
    logic m_clk_en;
    int   m_cnt;

    uvma_clknrst_rst_seq #(.CNT_W(CNT_W), .SETTLE_CYCLES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_cycles  (cmd_cycles),
        .dut_reset_n (dut_reset_n),
        .clk_en      (clk_en),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rst_count   (rst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat(input int c);
        return (c >= 255) ? 255 : c + 1;
    endfunction

    // {cmd_ready, dut_reset_n, clk_en, busy, done, err, rst_count}
    function automatic logic [13:0] sample();
        return {cmd_ready, dut_reset_n, clk_en, busy, done, err, rst_count};
    endfunction

    function automatic logic [13:0] model_idle();
        return {1'b1, m_rst_n, m_clk_en, 3'b000, 8'(m_cnt)};
    endfunction

    // Expected pins k cycles after a command was accepted.
    function automatic logic [13:0] model_at(input int op, input int n, input int k);
        logic rdy, rn, ce, bs, dn, er;
        int   cnt, ne;
        rdy = 1'b1; rn = m_rst_n; ce = m_clk_en; bs = 1'b0; dn = 1'b0; er = 1'b0;
        cnt = m_cnt;
        ne  = (n == 0) ? 1 : n;
        case (op)
            0: dn = (k == 1);
            1: begin rn = 1'b0; dn = (k == 1); end
            2: begin
                ce = 1'b1;
                if (m_rst_n) begin
                    dn = (k == 1);
                end else begin
                    rn = 1'b1; bs = (k <= S); rdy = !bs; dn = (k == S);
                    if (k >= S) cnt = sat(m_cnt);
                end
            end
            3: begin
                ce = 1'b1; rn = (k > ne); bs = (k <= ne + S); rdy = !bs;
                dn = (k == ne + S);
                if (k >= ne + S) cnt = sat(m_cnt);
            end
            4: begin
                if (n == 0) begin
                    ce = 1'b0; dn = (k == 1);
                end else begin
                    ce = (k > n); bs = (k <= n); rdy = !bs; dn = (k == n);
                end
            end
            5: begin ce = 1'b1; dn = (k == 1); end
            default: er = (k == 1);
        endcase
        return {rdy, rn, ce, bs, dn, er, 8'(cnt)};
    endfunction

    // Offset of the first idle (ready) cycle after acceptance.
    function automatic int model_len(input int op, input int n);
        case (op)
            2: return m_rst_n ? 1 : S + 1;
            3: return ((n == 0) ? 1 : n) + S + 1;
            4: return (n == 0) ? 1 : n + 1;
            default: return 1;
        endcase
    endfunction

    task automatic model_commit(input int op, input int n);
        case (op)
            1: m_rst_n = 1'b0;
            2: begin
                if (!m_rst_n) m_cnt = sat(m_cnt);
                m_rst_n = 1'b1; m_clk_en = 1'b1;
            end
            3: begin m_cnt = sat(m_cnt); m_rst_n = 1'b1; m_clk_en = 1'b1; end
            4: m_clk_en = (n != 0);
            5: m_clk_en = 1'b1;
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_rst_n = 1'b0; m_clk_en = 1'b1; m_cnt = 0;
    endtask

    // Called at the negedge of a ready cycle; returns at the negedge of T+1.
    task automatic send(input int op, input int n);
        cmd_valid  = 1'b1;
        cmd_op     = 3'(op);
        cmd_cycles = CNT_W'(n);
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("txn op=%0d cycles=%0d accepted before t=%0t", op, n, $time);
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_cycles = '0;
        model_reset();
        repeat (4) @(negedge clk);
        obs = sample();
        n_checks++;
        if (obs !== 14'b0_0_1_0_0_0_00000000) begin
            n_fail++;
            $display("FAIL reset_values got=%h exp=%h", obs, 14'b0_0_1_0_0_0_00000000);
        end
        reset = 1'b0;
        @(negedge clk);
        obs = sample();
        n_checks++;
        if (obs !== model_idle()) begin
            n_fail++;
            $display("FAIL reset_release got=%h exp=%h", obs, model_idle());
        end
    endtask

    task automatic test_pulse();
        int ops[6]  = '{3, 3, 1, 2, 2, 3};
        int cyc[6]  = '{3, 0, 0, 0, 0, 2};
        logic [13:0] obs, exp;
        for (int i = 0; i < 6; i++) begin
            send(ops[i], cyc[i]);
            for (int k = 1; k <= model_len(ops[i], cyc[i]); k++) begin
                if (k > 1) @(negedge clk);
                obs = sample(); exp = model_at(ops[i], cyc[i], k);
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL pulse_deassert op=%0d n=%0d k=%0d got=%h exp=%h", ops[i], cyc[i], k, obs, exp);
                end
            end
            model_commit(ops[i], cyc[i]);
        end
    endtask

    task automatic test_clk_stop();
        int ops[4] = '{4, 4, 5, 4};
        int cyc[4] = '{5, 0, 0, 1};
        logic [13:0] obs, exp;
        for (int i = 0; i < 4; i++) begin
            send(ops[i], cyc[i]);
            for (int k = 1; k <= model_len(ops[i], cyc[i]); k++) begin
                if (k > 1) @(negedge clk);
                obs = sample(); exp = model_at(ops[i], cyc[i], k);
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL clk_stop op=%0d n=%0d k=%0d got=%h exp=%h", ops[i], cyc[i], k, obs, exp);
                end
            end
            model_commit(ops[i], cyc[i]);
            if (i == 1) begin
                repeat (100) begin
                    @(negedge clk);
                    obs = sample();
                    n_checks++;
                    if (obs !== model_idle()) begin
                        n_fail++;
                        $display("FAIL clk_held_off got=%h exp=%h", obs, model_idle());
                    end
                end
            end
        end
    endtask

    task automatic test_illegal_and_hold();
        logic [13:0] obs, exp;
        for (int op = 6; op <= 7; op++) begin
            send(op, 9);
            for (int k = 1; k <= 3; k++) begin
                if (k > 1) @(negedge clk);
                obs = sample();
                exp = (k == 1) ? model_at(op, 9, 1) : model_idle();
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL illegal op=%0d k=%0d got=%h exp=%h", op, k, obs, exp);
                end
            end
        end
        // valid stays high with a NOP queued behind a PULSE
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_cycles = CNT_W'(2);
        @(negedge clk);
        cmd_op = 3'd0;
        for (int k = 1; k <= model_len(3, 2); k++) begin
            if (k > 1) @(negedge clk);
            obs = sample(); exp = model_at(3, 2, k);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL hold_valid k=%0d got=%h exp=%h", k, obs, exp);
            end
        end
        model_commit(3, 2);
        @(negedge clk);
        cmd_valid = 1'b0;
        obs = sample(); exp = model_at(0, 0, 1);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL hold_valid_nop got=%h exp=%h", obs, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] obs, exp;
        int cut[3] = '{2, 0, 3};
        int cyc[3] = '{5, 1, 1};
        for (int i = 0; i < 3; i++) begin
            send(3, cyc[i]);
            for (int k = 1; k <= ((cut[i] == 0) ? model_len(3, cyc[i]) : cut[i]); k++) begin
                if (k > 1) @(negedge clk);
                obs = sample(); exp = model_at(3, cyc[i], k);
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL reset_mid_pre i=%0d k=%0d got=%h exp=%h", i, k, obs, exp);
                end
            end
            if (cut[i] == 0) begin
                model_commit(3, cyc[i]);
            end else begin
                reset = 1'b1;
                @(negedge clk);
                obs = sample();
                n_checks++;
                if (obs !== 14'b0_0_1_0_0_0_00000000) begin
                    n_fail++;
                    $display("FAIL reset_mid i=%0d got=%h exp=%h", i, obs, 14'b0_0_1_0_0_0_00000000);
                end
                reset = 1'b0;
                model_reset();
                @(negedge clk);
                obs = sample();
                n_checks++;
                if (obs !== model_idle()) begin
                    n_fail++;
                    $display("FAIL reset_mid_after i=%0d got=%h exp=%h", i, obs, model_idle());
                end
            end
        end
    endtask

    task automatic test_random();
        logic [13:0] obs, exp;
        int op, n;
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 7));
            n  = int'($urandom_range(0, 6));
            send(op, n);
            for (int k = 1; k <= model_len(op, n); k++) begin
                if (k > 1) @(negedge clk);
                obs = sample(); exp = model_at(op, n, k);
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL random op=%0d n=%0d k=%0d got=%h exp=%h", op, n, k, obs, exp);
                end
            end
            model_commit(op, n);
        end
    endtask

    task automatic test_saturate();
        logic [13:0] obs, exp;
        for (int i = 0; i < 260; i++) begin
            send(3, 1);
            for (int k = 1; k <= model_len(3, 1); k++) begin
                if (k > 1) @(negedge clk);
                obs = sample(); exp = model_at(3, 1, k);
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL saturate i=%0d k=%0d got=%h exp=%h", i, k, obs, exp);
                end
            end
            model_commit(3, 1);
        end
        n_checks++;
        if (rst_count !== 8'd255) begin
            n_fail++;
            $display("FAIL saturate_final got=%0d exp=255", rst_count);
        end
    endtask

    initial begin
        test_reset();
        test_pulse();
        test_clk_stop();
        test_illegal_and_hold();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
